// File: rtl/ntsc_pixel_packer_pkg.sv
// Shared constants for the NTSC capture path: frame geometry, word layout, FSM encodings.
// Also provides the helper that packs two truncated pixels into one SRAM word.
package ntsc_pixel_packer_pkg;

  localparam int IMAGE_WIDTH  = 640;
  localparam int IMAGE_HEIGHT = 240;
  localparam int IMAGE_LENGTH = IMAGE_WIDTH * IMAGE_HEIGHT / 2;
  localparam int LOG_MEM      = $clog2(IMAGE_LENGTH);
  localparam int FIFO_DEPTH   = 8;
  localparam int PIX_W        = 18;
  localparam int MEM_W        = 2 * PIX_W;

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_CAPT  = 2'd1;
  localparam logic [1:0] ST_PAD   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [MEM_W-1:0] word_t;

  // Even (left) pixel occupies the upper half of the word.
  function automatic word_t pack_word(input pix_t even_pix, input pix_t odd_pix);
    return {even_pix, odd_pix};
  endfunction

endpackage

// File: rtl/ntsc_pixel_packer_fifo.sv
// Show-ahead synchronous FIFO; head word visible combinationally, zero when empty.
// Latency 1 cycle push-to-empty-deassert; push+pop together is accepted even when full.
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/ntsc_pixel_packer.sv
// Crops one even NTSC field, truncates to 18b pixels, packs pairs into 36b words for SRAM capture.
// Odd pixel to ntsc_flag: 2 edges; FIFO full drops words (sticky overflow), done_ntsc pops the head.
module ntsc_pixel_packer #(
  parameter int IMAGE_WIDTH  = ntsc_pixel_packer_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = ntsc_pixel_packer_pkg::IMAGE_HEIGHT,
  parameter int FIFO_DEPTH   = ntsc_pixel_packer_pkg::FIFO_DEPTH
) (
  input  logic                                  clock,
  input  logic                                  reset_b,
  input  logic [29:0]                           ntsc_ycrcb,
  input  logic                                  ntsc_dv,
  input  logic                                  ntsc_f,
  input  logic                                  ntsc_v,
  input  logic                                  ntsc_h,
  input  logic                                  done_ntsc,
  output logic                                  ntsc_flag,
  output logic [ntsc_pixel_packer_pkg::MEM_W-1:0] ntsc_pixel,
  output logic                                  frame_flag,
  output logic                                  overflow
);

  import ntsc_pixel_packer_pkg::*;

  localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT / 2;
  localparam int WCW   = $clog2(TOTAL + 1);
  localparam int XW    = $clog2(IMAGE_WIDTH + 1);
  localparam int YW    = $clog2(IMAGE_HEIGHT + 1);
  localparam logic [WCW-1:0] TOTAL_C = WCW'(TOTAL);
  localparam logic [XW-1:0]  X_MAX   = XW'(IMAGE_WIDTH);
  localparam logic [YW-1:0]  Y_MAX   = YW'(IMAGE_HEIGHT);

  logic [1:0]     state;
  logic           v_q;
  logic           h_q;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic           line_open;
  pix_t           hold;
  logic           push_vld;
  word_t          push_dat;
  logic [WCW-1:0] word_cnt;
  logic           fifo_full;
  logic           fifo_empty;

  logic v_fall, v_rise, h_fall, sample, drop;
  pix_t pix;
  logic unused_lsbs;

  assign v_fall = v_q & ~ntsc_v;
  assign v_rise = ~v_q & ntsc_v;
  assign h_fall = h_q & ~ntsc_h;
  assign pix    = {ntsc_ycrcb[29:24], ntsc_ycrcb[19:14], ntsc_ycrcb[9:4]};
  assign sample = ntsc_dv & line_open & (x < X_MAX) & (y < Y_MAX);
  // Full FIFO implies non-empty, so any done_ntsc frees the slot this push needs.
  assign drop   = push_vld & fifo_full & ~done_ntsc;
  assign ntsc_flag   = ~fifo_empty;
  assign unused_lsbs = ^{ntsc_ycrcb[23:20], ntsc_ycrcb[13:10], ntsc_ycrcb[3:0]};

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state      <= ST_WAIT;
      v_q        <= 1'b0;
      h_q        <= 1'b0;
      x          <= '0;
      y          <= '0;
      line_open  <= 1'b0;
      hold       <= '0;
      push_vld   <= 1'b0;
      push_dat   <= '0;
      word_cnt   <= '0;
      frame_flag <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      v_q        <= ntsc_v;
      h_q        <= ntsc_h;
      push_vld   <= 1'b0;
      frame_flag <= 1'b0;
      if (drop) overflow <= 1'b1;
      case (state)
        ST_WAIT: begin
          if (v_fall && !ntsc_f) begin
            state     <= ST_CAPT;
            x         <= '0;
            y         <= '0;
            line_open <= 1'b0;
            word_cnt  <= '0;
          end
        end
        ST_CAPT: begin
          if (v_rise) begin
            state <= ST_PAD;
          end else if (h_fall) begin
            // The first falling edge opens line 0; later ones advance the line.
            x         <= '0;
            line_open <= 1'b1;
            if (line_open && (y < Y_MAX)) y <= y + 1'b1;
          end else if (sample) begin
            x <= x + 1'b1;
            if (!x[0]) begin
              hold <= pix;
            end else begin
              push_vld <= 1'b1;
              push_dat <= pack_word(hold, pix);
              word_cnt <= word_cnt + 1'b1;
              if (word_cnt == TOTAL_C - 1'b1) state <= ST_DRAIN;
            end
          end
        end
        ST_PAD: begin
          if (word_cnt == TOTAL_C) begin
            state <= ST_DRAIN;
          end else if (!fifo_full && !push_vld) begin
            push_vld <= 1'b1;
            push_dat <= '0;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == TOTAL_C - 1'b1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty && !push_vld) begin
            frame_flag <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (MEM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_b  (reset_b),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (done_ntsc),
    .pop_dat  (ntsc_pixel),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ntsc_pixel_packer.sv
// Scoreboard bench: two packer instances (W=4,H=2 and W=4,H=3, FIFO depth 4) driven by directed fields.
module tb_ntsc_pixel_packer;

  logic        clock;
  logic        reset_b;
  logic        reset_b2;
  logic [29:0] ntsc_ycrcb;
  logic        ntsc_dv;
  logic        ntsc_f;
  logic        ntsc_v;
  logic        ntsc_h;
  logic        done_ntsc = 1'b0;
  logic        done2;
  logic        ntsc_flag, ntsc_flag2;
  logic [35:0] ntsc_pixel, ntsc_pixel2;
  logic        frame_flag, frame_flag2;
  logic        overflow, overflow2;

  int errors = 0;
  int checks = 0;
  int frame_cnt = 0;
  int frame_cnt2 = 0;
  int flag_cycles = 0;
  logic ff_prev = 1'b0;
  logic auto_pop = 1'b0;
  logic pop_on_odd = 1'b0;
  logic [29:0] line_pix [4];
  logic [35:0] exp_q [$];
  logic [35:0] exp2 [$];

  ntsc_pixel_packer #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset_b(reset_b), .ntsc_ycrcb(ntsc_ycrcb), .ntsc_dv(ntsc_dv),
    .ntsc_f(ntsc_f), .ntsc_v(ntsc_v), .ntsc_h(ntsc_h), .done_ntsc(done_ntsc),
    .ntsc_flag(ntsc_flag), .ntsc_pixel(ntsc_pixel), .frame_flag(frame_flag), .overflow(overflow)
  );

  ntsc_pixel_packer #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .FIFO_DEPTH(4)) dut_ovf (
    .clock(clock), .reset_b(reset_b2), .ntsc_ycrcb(ntsc_ycrcb), .ntsc_dv(ntsc_dv),
    .ntsc_f(ntsc_f), .ntsc_v(ntsc_v), .ntsc_h(ntsc_h), .done_ntsc(done2),
    .ntsc_flag(ntsc_flag2), .ntsc_pixel(ntsc_pixel2), .frame_flag(frame_flag2), .overflow(overflow2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor for the H=2 instance: echoes ntsc_flag onto done_ntsc and scores each popped head.
  always @(negedge clock) begin
    if (auto_pop && ntsc_flag) begin
      done_ntsc = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h, expected no word", ntsc_pixel);
      end else begin
        check("word", {28'h0, ntsc_pixel}, {28'h0, exp_q.pop_front()});
      end
    end else begin
      done_ntsc = 1'b0;
    end
    if (ntsc_flag) flag_cycles++;
    if (frame_flag) begin
      frame_cnt++;
      check("frame_pulse_width", {63'h0, ff_prev}, 64'h0);
    end
    ff_prev = frame_flag;
  end

  // Monitor for the H=3 instance: pops are driven by the stimulus, checked here.
  always @(negedge clock) begin
    if (done2 && ntsc_flag2) begin
      if (exp2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word2: got %h, expected no word", ntsc_pixel2);
      end else begin
        check("word2", {28'h0, ntsc_pixel2}, {28'h0, exp2.pop_front()});
      end
    end
    if (frame_flag2) frame_cnt2++;
  end

  task automatic field_start(input logic f);
    ntsc_h = 1'b1;
    ntsc_v = 1'b1;
    ntsc_f = f;
    tick();
    tick();
    ntsc_v = 1'b0;
    tick();
  endtask

  task automatic send_line(input logic extra);
    ntsc_h = 1'b1;
    tick();
    ntsc_h = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      ntsc_dv = 1'b1;
      ntsc_ycrcb = line_pix[i];
      tick();
      if (pop_on_odd && (i % 2 == 1)) begin
        done2 = 1'b1;
        ntsc_dv = 1'b0;
        tick();
        done2 = 1'b0;
      end
    end
    if (extra) begin
      ntsc_dv = 1'b1;
      ntsc_ycrcb = 30'h3FFF_FFFF;
      tick();
    end
    ntsc_dv = 1'b0;
    ntsc_h = 1'b1;
    tick();
  endtask

  task automatic wait_frames(input int which, input int target, input string name);
    int n = 0;
    while (((which == 0) ? frame_cnt : frame_cnt2) < target && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'((which == 0) ? frame_cnt : frame_cnt2), 64'(target));
  endtask

  task automatic pop_all2();
    for (int n = 0; n < 12; n++) begin
      done2 = ntsc_flag2;
      tick();
    end
    done2 = 1'b0;
  endtask

  // Line-tagged pixel: Y carries the line/column, low nibbles are junk that truncation must drop.
  function automatic logic [29:0] mkpix(input int l, input int x);
    return {6'(l * 4 + x), 4'hF, 6'h2A, 4'h0, 6'(x + 1), 4'h7};
  endfunction

  function automatic logic [17:0] exppix(input int l, input int x);
    return {6'(l * 4 + x), 6'h2A, 6'(x + 1)};
  endfunction

  initial begin
    reset_b = 1'b0;
    reset_b2 = 1'b0;
    done2 = 1'b0;
    ntsc_ycrcb = '0;
    ntsc_dv = 1'b0;
    ntsc_f = 1'b0;
    ntsc_v = 1'b0;
    ntsc_h = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_flag", {63'h0, ntsc_flag}, 64'h0);
    check("reset_pixel", {28'h0, ntsc_pixel}, 64'h0);
    check("reset_frame_flag", {63'h0, frame_flag}, 64'h0);
    check("reset_overflow", {63'h0, overflow}, 64'h0);
    reset_b = 1'b1;
    tick();

    // Reset in the middle of a field: FIFO flushed at once, capture waits for a new field.
    for (int i = 0; i < 4; i++) line_pix[i] = {10'h3FF, 10'h000, 10'h200};
    field_start(1'b0);
    ntsc_h = 1'b1;
    tick();
    ntsc_h = 1'b0;
    tick();
    ntsc_dv = 1'b1;
    tick();
    tick();
    ntsc_dv = 1'b0;
    tick();
    check("midframe_flag_before_reset", {63'h0, ntsc_flag}, 64'h1);
    reset_b = 1'b0;
    #1;
    check("midframe_reset_flag", {63'h0, ntsc_flag}, 64'h0);
    check("midframe_reset_pixel", {28'h0, ntsc_pixel}, 64'h0);
    tick();
    reset_b = 1'b1;
    tick();
    flag_cycles = 0;
    send_line(1'b0);
    send_line(1'b0);
    repeat (10) tick();
    check("no_capture_after_reset", 64'(flag_cycles), 64'h0);
    check("no_frame_after_reset", 64'(frame_cnt), 64'h0);

    // Even field, 2 lines of Y=3FF Cr=0 Cb=200: Cb[9:4]=6'h20 so each pixel is 18'h3F020.
    auto_pop = 1'b1;
    repeat (4) exp_q.push_back({18'h3F020, 18'h3F020});
    field_start(1'b0);
    send_line(1'b1);
    send_line(1'b1);
    wait_frames(0, 1, "frame_after_full_field");
    check("queue_empty_full_field", 64'(exp_q.size()), 64'h0);

    // Odd field is never captured.
    flag_cycles = 0;
    field_start(1'b1);
    send_line(1'b0);
    send_line(1'b0);
    repeat (10) tick();
    check("odd_field_flag", 64'(flag_cycles), 64'h0);
    check("odd_field_frames", 64'(frame_cnt), 64'h1);

    // Short field: one line, then vertical blanking forces two zero pad words.
    line_pix[0] = {10'h3FF, 10'h000, 10'h000};
    line_pix[1] = {10'h000, 10'h3FF, 10'h000};
    line_pix[2] = {10'h000, 10'h000, 10'h3FF};
    line_pix[3] = {10'h15F, 10'h2A0, 10'h01F};
    exp_q.push_back({18'h3F000, 18'h00FC0});
    exp_q.push_back({18'h0003F, 18'h15A81});
    exp_q.push_back(36'h0);
    exp_q.push_back(36'h0);
    field_start(1'b0);
    ntsc_dv = 1'b1;
    ntsc_ycrcb = 30'h1234_5678;
    tick();
    ntsc_dv = 1'b0;
    send_line(1'b0);
    ntsc_v = 1'b1;
    wait_frames(0, 2, "frame_after_pad");
    check("queue_empty_pad", 64'(exp_q.size()), 64'h0);
    auto_pop = 1'b0;
    reset_b = 1'b0;

    // H=3 instance, no pops for a whole frame: words 5 and 6 are dropped.
    reset_b2 = 1'b1;
    tick();
    field_start(1'b0);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 4; i++) line_pix[i] = mkpix(l, i);
      if (l < 2) begin
        exp2.push_back({exppix(l, 0), exppix(l, 1)});
        exp2.push_back({exppix(l, 2), exppix(l, 3)});
      end
      send_line(1'b0);
    end
    repeat (3) tick();
    check("ovf_flag_held", {63'h0, ntsc_flag2}, 64'h1);
    check("ovf_head_is_first", {28'h0, ntsc_pixel2}, {28'h0, exppix(0, 0), exppix(0, 1)});
    check("ovf_sticky_set", {63'h0, overflow2}, 64'h1);
    check("ovf_no_early_frame", 64'(frame_cnt2), 64'h0);
    pop_all2();
    wait_frames(1, 1, "ovf_frame_after_drain");
    check("ovf_queue_empty", 64'(exp2.size()), 64'h0);
    check("ovf_still_set", {63'h0, overflow2}, 64'h1);
    reset_b2 = 1'b0;
    #1;
    check("ovf_cleared_by_reset", {63'h0, overflow2}, 64'h0);
    tick();
    reset_b2 = 1'b1;
    tick();

    // Full FIFO with a push and a pop in the same cycle: nothing lost, no overflow.
    field_start(1'b0);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 4; i++) line_pix[i] = mkpix(l, i);
      exp2.push_back({exppix(l, 0), exppix(l, 1)});
      exp2.push_back({exppix(l, 2), exppix(l, 3)});
      pop_on_odd = (l == 2);
      send_line(1'b0);
    end
    pop_on_odd = 1'b0;
    repeat (2) tick();
    check("simul_overflow_clear", {63'h0, overflow2}, 64'h0);
    check("simul_flag_held", {63'h0, ntsc_flag2}, 64'h1);
    check("simul_head_is_third", {28'h0, ntsc_pixel2}, {28'h0, exppix(1, 0), exppix(1, 1)});
    pop_all2();
    wait_frames(1, 2, "simul_frame_after_drain");
    check("simul_queue_empty", 64'(exp2.size()), 64'h0);
    check("simul_overflow_final", {63'h0, overflow2}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
